nn_polar_sng: RTL and testbench
===============================

Name: nn_polar_sng

Overview:
- Sign-magnitude (polar) stochastic number generator: converts an N-bit magnitude plus sign bit into a unipolar stochastic bitstream with a constant sign line.
- Encoding end of the polar stochastic interface consumed by the smooth-gradient polar integrator (IN_SS/SIGN).
- Drives weights and gradients into stochastic NN datapaths.
- A LOAD/BUSY/DONE handshake frames a stream of programmable length.

Parameters:
- N, 8, magnitude width and LFSR width. Supported values are 8, 9 and 10; any other value is a compile-time error.
- N_LEN, 8, stream-length counter width.
- LFSR_SEED, 8'hB4, LFSR reset value. Must be non-zero; it is truncated or zero-extended to N bits.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- INIT_N  input  1  asynchronous active-low reset.
- EN  input  1  clock enable for stream generation; also gates RUN progress.
- LOAD  input  1  start request; accepted only when BUSY=0.
- VAL_IN  input  N  magnitude to encode.
- SIGN_IN  input  1  polarity of the value (1 = negative).
- LEN  input  N_LEN  stream length in valid bits; 0 means 2^N_LEN.
- SS_OUT  output  1  stochastic bit; meaningful only when STREAM_VALID=1.
- SIGN_OUT  output  1  latched polarity of the current or last stream.
- STREAM_VALID  output  1  SS_OUT carries a stream bit this cycle.
- BUSY  output  1  stream in progress; LOAD is ignored while high.
- DONE  output  1  one-cycle pulse coincident with the final valid bit.

Behaviour:
- Reset (INIT_N low, asynchronous):
  - state=IDLE, LFSR=LFSR_SEED, counter=0.
  - Latched VAL and SIGN = 0.
  - SS_OUT, SIGN_OUT, STREAM_VALID, BUSY and DONE all 0.
- Reset asserted mid-stream aborts the stream immediately:
  - no DONE pulse is issued;
  - the LFSR returns to LFSR_SEED.
- FSM states: IDLE and RUN. BUSY = (state==RUN), registered.
- IDLE:
  - LOAD=1 latches VAL_IN, SIGN_IN and LEN (0 expands to 2^N_LEN) and sets state=RUN on that edge.
  - SIGN_OUT updates to the latched sign on the same edge.
  - LOAD=0: all outputs hold, except STREAM_VALID=0, DONE=0 and SS_OUT=0.
- RUN with EN=1, each edge:
  - SS_OUT <= (LFSR <= VAL_latched), unsigned compare.
  - STREAM_VALID <= 1.
  - LFSR advances one step.
  - counter decrements.
  - When counter=1: DONE <= 1 and state <= IDLE on the same edge.
- RUN with EN=0:
  - LFSR, counter and state hold.
  - STREAM_VALID <= 0, SS_OUT <= 0.
  - The stream is stretched, not shortened.
- Latency:
  - LOAD accepted at edge k; first valid bit appears after the first RUN edge with EN=1, i.e. edge k+1 at the earliest.
  - With EN tied high, exactly LEN consecutive STREAM_VALID cycles.
- Back-to-back streams:
  - In the DONE cycle BUSY is already 0, so LOAD asserted during DONE is accepted.
  - The next stream follows with no gap.
- LOAD during RUN is ignored, and latched values are unchanged.
- LFSR:
  - Fibonacci, maximal length, never zero, range 1..2^N-1.
  - Taps: N=8 {8,6,5,4}; N=9 {9,5}; N=10 {10,7}.
  - The LFSR is not reseeded on LOAD; successive streams continue the sequence for decorrelation.
- Density:
  - Over any full LFSR period (2^N-1 valid bits), the ones count equals VAL exactly.
  - VAL=0 gives all zeros; VAL=2^N-1 gives all ones.
- SIGN_OUT is constant for the whole stream, including when VAL=0.
- SIGN_OUT holds its value in IDLE until the next accepted LOAD.

Optional Feature:
- Macro: NN_SNG_POPCOUNT_EN.
- Defined:
  - Adds output ONES_CNT, width N_LEN+1.
  - ONES_CNT clears to 0 on accepted LOAD and on reset.
  - Increments on each cycle where STREAM_VALID=1 and SS_OUT=1.
  - Final value is valid in the DONE cycle and holds until the next accepted LOAD.
- Not defined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset: INIT_N=0 with EN=1 and LOAD=1 toggling -> all outputs 0 and BUSY=0; after release the first LOAD is accepted.
- Full period: LOAD with VAL=100, SIGN=1, LEN=255, EN=1 -> BUSY high next cycle, 255 consecutive valid bits, exactly 100 ones, SIGN_OUT=1 throughout, a single DONE on the 255th bit, BUSY=0 in that cycle.
- Extremes (LEN=255): VAL=0 -> 0 ones; VAL=255 -> 255 ones. A LOAD in the DONE cycle starts the next stream with zero gap.
- Enable gating: LEN=16 with EN alternating 1/0 -> exactly 16 valid bits spread over about 32 cycles; SS_OUT=0 and STREAM_VALID=0 on EN=0 cycles; DONE on the 16th valid bit.
- LEN=0, VAL=128: -> 256 valid bits; a second LOAD (VAL=5) issued mid-stream is ignored and the stream ends at 256; with NN_SNG_POPCOUNT_EN, ONES_CNT equals the ones counted by the bench.
- Mid-stream abort: INIT_N pulse at bit 40 -> immediate outputs 0, no DONE, LFSR=LFSR_SEED. Then a new LOAD (VAL=50, LEN=255) -> 50 ones, DONE at bit 255.

Source files
------------

// File: rtl/nn_polar_sng_if.sv
// nn_polar_sng_if: control, value and stream lines between a polar SNG and its user.
// Latency: none, wiring only.
// Backpressure: EN stalls the stream; LOAD is only honoured while BUSY is low.
// Optional: NN_SNG_POPCOUNT_EN adds the ONES_CNT line.
interface nn_polar_sng_if #(
    parameter int N     = 8,
    parameter int N_LEN = 8
);
    logic             EN;
    logic             LOAD;
    logic [N-1:0]     VAL_IN;
    logic             SIGN_IN;
    logic [N_LEN-1:0] LEN;
    logic             SS_OUT;
    logic             SIGN_OUT;
    logic             STREAM_VALID;
    logic             BUSY;
    logic             DONE;
`ifdef NN_SNG_POPCOUNT_EN
    logic [N_LEN:0]   ONES_CNT;

    modport master (
        output EN, LOAD, VAL_IN, SIGN_IN, LEN,
        input  SS_OUT, SIGN_OUT, STREAM_VALID, BUSY, DONE, ONES_CNT
    );

    modport slave (
        input  EN, LOAD, VAL_IN, SIGN_IN, LEN,
        output SS_OUT, SIGN_OUT, STREAM_VALID, BUSY, DONE, ONES_CNT
    );
`else
    modport master (
        output EN, LOAD, VAL_IN, SIGN_IN, LEN,
        input  SS_OUT, SIGN_OUT, STREAM_VALID, BUSY, DONE
    );

    modport slave (
        input  EN, LOAD, VAL_IN, SIGN_IN, LEN,
        output SS_OUT, SIGN_OUT, STREAM_VALID, BUSY, DONE
    );
`endif
endinterface

// File: rtl/nn_polar_sng.sv
// nn_polar_sng: sign-magnitude stochastic number generator (LFSR-compare unipolar stream plus constant sign line).
// Latency: LOAD accepted on edge k; first stream bit registered on the first RUN edge with EN=1 (k+1 earliest).
// Backpressure: EN=0 stalls the stream (no bit, LFSR/counter hold, stream stretched); LOAD ignored while BUSY.
// Optional: define NN_SNG_POPCOUNT_EN to add the ONES_CNT output.
module nn_polar_sng #(
    parameter int          N         = 8,
    parameter int          N_LEN     = 8,
    parameter int unsigned LFSR_SEED = 32'hB4
) (
    input  logic          CLK,
    input  logic          INIT_N,
    nn_polar_sng_if.slave bus
);
    // Seed is truncated or zero-extended to the LFSR width.
    localparam logic [N-1:0] SEED_N = N'(LFSR_SEED);

    // Fibonacci feedback taps (1-based {8,6,5,4}, {9,5}, {10,7}) as a bit mask.
    localparam logic [N-1:0] TAP_MASK = (N == 8) ? N'(8'b1011_1000) :
                                        (N == 9) ? N'(9'b1_0001_0000) :
                                                   N'(10'b10_0100_0000);

    localparam logic [N_LEN:0] CNT_ONE  = {{N_LEN{1'b0}}, 1'b1};
    localparam logic [N_LEN:0] CNT_FULL = {1'b1, {N_LEN{1'b0}}};

    if (N != 8 && N != 9 && N != 10) begin : g_bad_n
        $error("nn_polar_sng: N must be 8, 9 or 10");
    end
    if (SEED_N == '0) begin : g_bad_seed
        $error("nn_polar_sng: LFSR_SEED must be non-zero in the low N bits");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [N-1:0]   lfsr;
    logic [N-1:0]   lfsr_nxt;
    logic [N_LEN:0] cnt;
    logic [N_LEN:0] len_ext;
    logic [N-1:0]   val_q;
    logic           sign_q;
    logic           ss_q;
    logic           sv_q;
    logic           done_q;

    logic           load_acc;
    logic           step;
    logic           last;
    logic           ss_d;

    // LENGTH 0 stands for the full 2^N_LEN stream.
    assign len_ext  = (bus.LEN == '0) ? CNT_FULL : {1'b0, bus.LEN};
    assign lfsr_nxt = {lfsr[N-2:0], ^(lfsr & TAP_MASK)};

    // State register: only the IDLE/RUN flag lives here.
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: LOAD starts a stream from IDLE, the final enabled bit ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load_acc) state_nxt = S_RUN;
            S_RUN:   if (last)     state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: a stream bit is produced only on enabled RUN cycles.
    always_comb begin
        load_acc = (state == S_IDLE) && bus.LOAD;
        step     = (state == S_RUN) && bus.EN;
        last     = step && (cnt == CNT_ONE);
        ss_d     = step && (lfsr <= val_q);
    end

    // Datapath: latch the request, advance LFSR/counter per bit, register the stream outputs.
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            lfsr   <= SEED_N;
            cnt    <= '0;
            val_q  <= '0;
            sign_q <= 1'b0;
            ss_q   <= 1'b0;
            sv_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ss_q   <= ss_d;
            sv_q   <= step;
            done_q <= last;
            if (load_acc) begin
                val_q  <= bus.VAL_IN;
                sign_q <= bus.SIGN_IN;
                cnt    <= len_ext;
            end else if (step) begin
                // The LFSR is never reseeded on LOAD so back-to-back streams stay decorrelated.
                lfsr <= lfsr_nxt;
                cnt  <= cnt - CNT_ONE;
            end
        end
    end

`ifdef NN_SNG_POPCOUNT_EN
    logic [N_LEN:0] ones_q;

    // Ones counter counts the bit being produced so the DONE cycle already shows the final total.
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            ones_q <= '0;
        end else if (load_acc) begin
            ones_q <= '0;
        end else if (ss_d) begin
            ones_q <= ones_q + CNT_ONE;
        end
    end

    assign bus.ONES_CNT = ones_q;
`endif

    assign bus.SS_OUT       = ss_q;
    assign bus.SIGN_OUT     = sign_q;
    assign bus.STREAM_VALID = sv_q;
    assign bus.BUSY         = (state == S_RUN);
    assign bus.DONE         = done_q;

endmodule

// File: tb/tb_nn_polar_sng.sv
// tb_nn_polar_sng: scoreboard bench for nn_polar_sng, expected bits queued at LOAD, checked by a monitor.
// Latency: expects first bit on the first enabled RUN edge after the LOAD edge.
// Backpressure: EN patterns (constant, alternating, random) stretch streams; LOAD probes during RUN.
module tb_nn_polar_sng;
    localparam int N      = 8;
    localparam int N_LEN  = 8;
    localparam int PERIOD = 255;

    logic clk    = 1'b0;
    logic init_n = 1'b1;

    always #5 clk = ~clk;

    nn_polar_sng_if #(.N(N), .N_LEN(N_LEN)) sif ();

    nn_polar_sng #(
        .N         (N),
        .N_LEN     (N_LEN),
        .LFSR_SEED (32'hB4)
    ) dut (
        .CLK    (clk),
        .INIT_N (init_n),
        .bus    (sif.slave)
    );

    typedef struct {
        bit ss;
        bit done;
        bit sign;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] seq[PERIOD];
    int         pos       = 0;
    int         total     = 0;
    int         bad       = 0;
    bit         last_sign = 1'b0;

    function automatic void check(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endfunction

    function automatic void check1(string name, logic got, logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b at %0t", name, got, want, $time);
        end
    endfunction

    // Reference LFSR sequence from the seed and taps {8,6,5,4}; index = valid bits since reset mod period.
    function automatic void build_seq();
        logic [7:0] s;
        s = 8'hB4;
        for (int i = 0; i < PERIOD; i++) begin
            seq[i] = s;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
    endfunction

    // Queue the expected stream; returns its ones count.
    function automatic int push_stream(int val, bit sgn, int len_eff);
        int ones;
        exp_t e;
        ones = 0;
        for (int j = 0; j < len_eff; j++) begin
            e.ss   = (int'(seq[pos]) <= val);
            e.done = (j == len_eff - 1);
            e.sign = sgn;
            exp_q.push_back(e);
            if (e.ss) ones++;
            pos = (pos + 1) % PERIOD;
        end
        return ones;
    endfunction

    function automatic void check_outputs_zero(string tag);
        check1({tag, "_ss_out"},       sif.SS_OUT,       1'b0);
        check1({tag, "_sign_out"},     sif.SIGN_OUT,     1'b0);
        check1({tag, "_stream_valid"}, sif.STREAM_VALID, 1'b0);
        check1({tag, "_busy"},         sif.BUSY,         1'b0);
        check1({tag, "_done"},         sif.DONE,         1'b0);
`ifdef NN_SNG_POPCOUNT_EN
        check({tag, "_ones_cnt"}, int'(sif.ONES_CNT), 0);
`endif
    endfunction

    // Monitor: every valid bit is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sif.STREAM_VALID) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check1("ss_out",   sif.SS_OUT,   e.ss);
                    check1("done",     sif.DONE,     e.done);
                    check1("sign_out", sif.SIGN_OUT, e.sign);
                    check1("busy",     sif.BUSY,     !e.done);
                end
            end else begin
                check1("ss_out_when_invalid", sif.SS_OUT, 1'b0);
                check1("done_when_invalid",   sif.DONE,   1'b0);
            end
        end
    end

    // en_mode: 0 = EN high, 1 = alternating 1/0, 2 = random. mid_load_at / abort_at: bit index or -1.
    task automatic run_stream(input int val, input bit sgn, input int len, input int en_mode,
                              input int mid_load_at, input int abort_at);
        int len_eff;
        int exp_ones;
        int nvalid;
        int nones;
        int cycles;
        int budget;
        bit got_done;
        bit aborted;
        bit mid_done;
        bit en_cur;
        len_eff  = (len == 0) ? 256 : len;
        nvalid   = 0;
        nones    = 0;
        cycles   = 0;
        budget   = 8 * len_eff + 16;
        got_done = 1'b0;
        aborted  = 1'b0;
        mid_done = 1'b0;

        check1("busy_before_load", sif.BUSY, 1'b0);
        sif.LOAD    = 1'b1;
        sif.VAL_IN  = 8'(val);
        sif.SIGN_IN = sgn;
        sif.LEN     = 8'(len);
        exp_ones    = push_stream(val, sgn, len_eff);
        @(negedge clk);
        sif.LOAD = 1'b0;
        check1("busy_after_load", sif.BUSY, 1'b1);
        check1("sign_out_on_load", sif.SIGN_OUT, sgn);
`ifdef NN_SNG_POPCOUNT_EN
        check("ones_cnt_cleared", int'(sif.ONES_CNT), 0);
`endif

        while (!got_done && !aborted && cycles < budget) begin
            sif.LOAD = 1'b0;
            if (mid_load_at >= 0 && nvalid == mid_load_at && !mid_done) begin
                sif.LOAD    = 1'b1;
                sif.VAL_IN  = 8'd5;
                sif.SIGN_IN = !sgn;
                sif.LEN     = 8'd3;
                mid_done    = 1'b1;
            end
            case (en_mode)
                0:       en_cur = 1'b1;
                1:       en_cur = ((cycles % 2) == 0);
                default: en_cur = ($urandom_range(0, 3) != 0);
            endcase
            sif.EN = en_cur;
            @(negedge clk);
            cycles++;
            check1("valid_follows_en", sif.STREAM_VALID, en_cur);
            if (sif.STREAM_VALID) begin
                nvalid++;
                if (sif.SS_OUT) nones++;
            end
            if (sif.DONE) begin
                got_done = 1'b1;
                check("done_on_last_bit", nvalid, len_eff);
`ifdef NN_SNG_POPCOUNT_EN
                check("ones_cnt_at_done", int'(sif.ONES_CNT), nones);
`endif
            end
            if (abort_at >= 0 && nvalid == abort_at && !got_done) begin
                #1 init_n = 1'b0;
                #1 check_outputs_zero("abort");
                exp_q.delete();
                pos       = 0;
                last_sign = 1'b0;
                @(negedge clk);
                check_outputs_zero("abort_hold");
                init_n  = 1'b1;
                aborted = 1'b1;
            end
        end
        sif.LOAD = 1'b0;

        if (!aborted) begin
            check1("done_seen", got_done, 1'b1);
            check("valid_count", nvalid, len_eff);
            if (len_eff == PERIOD) begin
                check("ones_full_period", nones, val);
            end else begin
                check("ones_vs_model", nones, exp_ones);
            end
            if (en_mode == 1) begin
                check("gated_cycles", cycles, 2 * len_eff - 1);
            end
            last_sign = sgn;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            sif.LOAD = 1'b0;
            sif.EN   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check1("sign_hold_idle", sif.SIGN_OUT, last_sign);
            check1("busy_idle", sif.BUSY, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rval;
        int rlen;
        build_seq();
        sif.LOAD    = 1'b0;
        sif.EN      = 1'b0;
        sif.VAL_IN  = '0;
        sif.SIGN_IN = 1'b0;
        sif.LEN     = '0;

        // Reset with EN high and LOAD toggling: everything must stay cleared.
        #2 init_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sif.EN      = 1'b1;
            sif.LOAD    = i[0];
            sif.VAL_IN  = 8'hFF;
            sif.SIGN_IN = 1'b1;
            @(negedge clk);
            check_outputs_zero("reset");
        end
        sif.LOAD = 1'b0;
        init_n   = 1'b1;

        // Full period then the two extremes, each LOAD issued in the previous DONE cycle.
        run_stream(100, 1'b1, 255, 0, -1, -1);
        run_stream(0,   1'b0, 255, 0, -1, -1);
        run_stream(255, 1'b1, 255, 0, -1, -1);
        idle_cycles(3);

        // Enable gating.
        run_stream(77, 1'b0, 16, 1, -1, -1);
        idle_cycles(2);

        // LEN=0 -> 256 bits, LOAD mid-stream ignored.
        run_stream(128, 1'b0, 0, 0, 100, -1);

        // Abort at bit 40, then a fresh full period from the seed.
        run_stream(200, 1'b1, 60, 0, -1, 40);
        run_stream(50, 1'b0, 255, 0, -1, -1);

        // Random streams with random enable and idle gaps.
        for (int k = 0; k < 12; k++) begin
            rval = int'($urandom_range(0, 255));
            rlen = int'($urandom_range(0, 40));
            run_stream(rval, 1'($urandom_range(0, 1)), rlen, ($urandom_range(0, 1) == 0) ? 0 : 2, -1, -1);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        idle_cycles(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
